// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state encodings and op-class predicates for muldiv_iter
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_DIV   = 3'd0,
    OP_DIVU  = 3'd1,
    OP_MULT  = 3'd2,
    OP_MULTU = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  function automatic logic is_div(input muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_signed(input muldiv_op_t op);
    return op inside {OP_DIV, OP_MULT, OP_MADD, OP_MSUB};
  endfunction

  function automatic logic is_acc(input muldiv_op_t op);
    return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_sub(input muldiv_op_t op);
    return op inside {OP_MSUB, OP_MSUBU};
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - execute-stage request/result bundle for muldiv_iter
interface muldiv_if import muldiv_pkg::*; #(
  parameter int WIDTH = 32
) ();

  logic                 start_i;
  logic                 annul_i;
  muldiv_op_t           op_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic [2*WIDTH-1:0]   acc_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 busy_o;
  logic                 div_zero_o;

  modport master (
    output start_i, annul_i, op_i, opdata1_i, opdata2_i, acc_i,
    input  result_o, ready_o, busy_o, div_zero_o
  );

  modport slave (
    input  start_i, annul_i, op_i, opdata1_i, opdata2_i, acc_i,
    output result_o, ready_o, busy_o, div_zero_o
  );

endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration: restoring-divide bit or shift-add multiply bit
// Divide: a = partial remainder, b = dividend shifting out / quotient shifting in. Multiply: {a,b} = product/multiplier.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             mode_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o
);

  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] rem_diff;
  logic           rem_ge;
  logic [WIDTH:0] mul_sum;

  assign rem_shift = {a_i, b_i[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, d_i};
  assign rem_ge    = rem_shift >= {1'b0, d_i};
  assign mul_sum   = {1'b0, a_i} + (b_i[0] ? {1'b0, d_i} : '0);

  always_comb begin
    a_o = a_i;
    b_o = b_i;
    if (mode_div_i) begin
      // Remainder stays below the divisor, so the difference always fits WIDTH bits.
      a_o = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      b_o = {b_i[WIDTH-2:0], rem_ge};
    end else begin
      a_o = mul_sum[WIDTH:1];
      b_o = {mul_sum[0], b_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative signed/unsigned multiply, divide and multiply-accumulate/subtract
module muldiv_iter import muldiv_pkg::*; #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int N  = WIDTH / UNROLL;
  localparam int CW = $clog2(N + 1);

  muldiv_state_t      state_q, state_d;
  muldiv_op_t         op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, d_q, d_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, result_q, result_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic               sign1, sign2;
  logic [WIDTH-1:0]   abs1, abs2;
  logic               mode_div;
  logic [WIDTH-1:0]   a_run, b_run;
  logic [2*WIDTH-1:0] prod_fix, fix_res;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign sign1 = is_signed(bus.op_i) & bus.opdata1_i[WIDTH-1];
  assign sign2 = is_signed(bus.op_i) & bus.opdata2_i[WIDTH-1];
  assign abs1  = sign1 ? -bus.opdata1_i : bus.opdata1_i;
  assign abs2  = sign2 ? -bus.opdata2_i : bus.opdata2_i;

  assign mode_div = is_div(op_q);

  // Separate per-stage nets keep the unrolled chain free of self-referencing arrays.
  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    logic [WIDTH-1:0] a_in, b_in, a_out, b_out;
    if (g == 0) begin : g_first
      assign a_in = a_q;
      assign b_in = b_q;
    end else begin : g_next
      assign a_in = g_step[g-1].a_out;
      assign b_in = g_step[g-1].b_out;
    end
    muldiv_step #(.WIDTH(WIDTH)) u_step (
      .mode_div_i (mode_div),
      .a_i        (a_in),
      .b_i        (b_in),
      .d_i        (d_q),
      .a_o        (a_out),
      .b_o        (b_out)
    );
  end

  assign a_run = g_step[UNROLL-1].a_out;
  assign b_run = g_step[UNROLL-1].b_out;

  assign prod_fix = qneg_q ? -{a_q, b_q} : {a_q, b_q};
  assign quo_fix  = qneg_q ? -b_q : b_q;
  assign rem_fix  = rneg_q ? -a_q : a_q;

  always_comb begin
    fix_res = prod_fix;
    if (is_div(op_q)) begin
      fix_res = {rem_fix, quo_fix};
    end else if (is_sub(op_q)) begin
      fix_res = acc_q - prod_fix;
    end else if (is_acc(op_q)) begin
      fix_res = acc_q + prod_fix;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    acc_d    = acc_q;
    result_d = result_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          op_d   = bus.op_i;
          acc_d  = bus.acc_i;
          qneg_d = sign1 ^ sign2;
          rneg_d = sign1;
          a_d    = '0;
          cnt_d  = CW'(N);
          if (is_div(bus.op_i)) begin
            b_d = abs1;
            d_d = abs2;
          end else begin
            b_d = abs2;
            d_d = abs1;
          end
          if (is_div(bus.op_i) && bus.opdata2_i == '0) begin
            result_d = '0;
            dz_d     = 1'b1;
            state_d  = DONE;
          end else begin
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        a_d   = a_run;
        b_d   = b_run;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = fix_res;
        state_d  = DONE;
      end
      DONE: begin
        if (!bus.start_i) begin
          dz_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Annul wins over everything, including a start seen in IDLE; the last result is kept.
    if (bus.annul_i) begin
      state_d  = IDLE;
      dz_d     = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= OP_DIV;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.result_o   = result_q;
  assign bus.ready_o    = (state_q == DONE);
  assign bus.busy_o     = (state_q == RUN) || (state_q == FIX);
  assign bus.div_zero_o = dz_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - bench driving UNROLL=1 and UNROLL=4 instances with identical requests
module tb_muldiv_iter;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, annul;
  logic [2:0]  op;
  logic [31:0] opd1, opd2;
  logic [63:0] acc;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) if1 ();
  muldiv_if #(.WIDTH(32)) if4 ();

  assign if1.start_i   = start;
  assign if1.annul_i   = annul;
  assign if1.op_i      = muldiv_op_t'(op);
  assign if1.opdata1_i = opd1;
  assign if1.opdata2_i = opd2;
  assign if1.acc_i     = acc;
  assign if4.start_i   = start;
  assign if4.annul_i   = annul;
  assign if4.op_i      = muldiv_op_t'(op);
  assign if4.opdata1_i = opd1;
  assign if4.opdata2_i = opd2;
  assign if4.acc_i     = acc;

  muldiv_iter #(.WIDTH(32), .UNROLL(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  muldiv_iter #(.WIDTH(32), .UNROLL(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

  int          n_chk = 0;
  int          n_bad = 0;
  logic [63:0] last_res1 = '0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] acc;
    logic [63:0] res;
    logic        dz;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] ac, input logic [63:0] r, input logic z);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.acc = ac; v.res = r; v.dz = z;
    tbl.push_back(v);
  endtask

  // Reference: plain 64-bit arithmetic, truncating signed division.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] ac, output logic [63:0] res, output logic dz);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = '0;
    dz  = 1'b0;
    if (o == 3'd0 || o == 3'd1) begin
      if (b == 32'd0) begin
        dz = 1'b1;
      end else if (o == 3'd0) begin
        sq  = sa / sb;
        sr  = sa % sb;
        res = {sr[31:0], sq[31:0]};
      end else begin
        uq  = ua / ub;
        ur  = ua % ub;
        res = {ur[31:0], uq[31:0]};
      end
    end else begin
      p = o[0] ? ua * ub : longint'(sa * sb);
      if (o >= 3'd6)      res = ac - p;
      else if (o >= 3'd4) res = ac + p;
      else                res = p;
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] ac, input logic [63:0] er, input logic edz,
                        input bit scramble, input string tag);
    int lat1, lat4;
    int exp1, exp4;
    exp1 = edz ? 1 : 34;
    exp4 = edz ? 1 : 10;
    lat1 = 0;
    lat4 = 0;
    op = o; opd1 = a; opd2 = b; acc = ac; start = 1'b1;
    for (int c = 1; c <= 80 && (lat1 == 0 || lat4 == 0); c++) begin
      tick();
      if (c == 1) begin
        chk({tag, " busy1@1"}, 64'(if1.busy_o), 64'(!edz));
        chk({tag, " busy4@1"}, 64'(if4.busy_o), 64'(!edz));
      end
      if (scramble && c == 2) begin
        op = 3'($urandom_range(0, 7)); opd1 = $urandom; opd2 = $urandom; acc = {$urandom, $urandom};
      end
      if (lat1 == 0 && if1.ready_o) lat1 = c;
      if (lat4 == 0 && if4.ready_o) lat4 = c;
    end
    chk({tag, " latency u1"}, 64'(lat1), 64'(exp1));
    chk({tag, " latency u4"}, 64'(lat4), 64'(exp4));
    chk({tag, " result u1"}, if1.result_o, er);
    chk({tag, " result u4"}, if4.result_o, er);
    chk({tag, " div_zero u1"}, 64'(if1.div_zero_o), 64'(edz));
    chk({tag, " div_zero u4"}, 64'(if4.div_zero_o), 64'(edz));
    tick();
    chk({tag, " held ready u1"}, 64'(if1.ready_o), 64'd1);
    chk({tag, " held result u1"}, if1.result_o, er);
    start = 1'b0;
    tick();
    chk({tag, " ready drop u1"}, 64'(if1.ready_o), 64'd0);
    chk({tag, " ready drop u4"}, 64'(if4.ready_o), 64'd0);
    chk({tag, " dz clear u1"}, 64'(if1.div_zero_o), 64'd0);
    chk({tag, " dz clear u4"}, 64'(if4.div_zero_o), 64'd0);
    last_res1 = er;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] er;
    logic        edz;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    logic [63:0] racc;
    bit          rose;

    rst = 1'b0; start = 1'b0; annul = 1'b0; op = 3'd0; opd1 = '0; opd2 = '0; acc = '0;
    repeat (3) tick();
    chk("reset result", if1.result_o, 64'd0);
    chk("reset ready", 64'(if1.ready_o), 64'd0);
    chk("reset busy", 64'(if1.busy_o), 64'd0);
    chk("reset dz", 64'(if4.div_zero_o), 64'd0);
    rst = 1'b1;
    tick();

    add(3'd0, 32'hFFFF_FFF9, 32'h2,         64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    add(3'd1, 32'hFFFF_FFFF, 32'h10,        64'd0, 64'h0000_000F_0FFF_FFFF, 1'b0);
    add(3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 64'h0000_0000_8000_0000, 1'b0);
    add(3'd0, 32'h0000_1234, 32'h0,         64'd0, 64'd0,                   1'b1);
    add(3'd1, 32'hDEAD_BEEF, 32'h0,         64'd0, 64'd0,                   1'b1);
    add(3'd0, 32'h7,         32'hFFFF_FFFE, 64'd0, 64'h0000_0001_FFFF_FFFD, 1'b0);
    add(3'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 64'd0, 64'hFFFF_FFFF_0000_0003, 1'b0);
    add(3'd1, 32'd100,       32'd7,         64'd0, 64'h0000_0002_0000_000E, 1'b0);
    add(3'd2, 32'h8000_0000, 32'h8000_0000, 64'd0, 64'h4000_0000_0000_0000, 1'b0);
    add(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001, 1'b0);
    add(3'd6, 32'd3,         32'd5,         64'h10, 64'h1,                  1'b0);
    add(3'd4, 32'hFFFF_FFFE, 32'd3,         64'd0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
    add(3'd3, 32'd12345,     32'd6789,      64'd0, 64'h0000_0000_04FE_D79D, 1'b0);
    add(3'd5, 32'd1,         32'd1,         64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
    add(3'd7, 32'd1,         32'd1,         64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].acc, tbl[i].res, tbl[i].dz, 1'b0,
             $sformatf("vec%0d", i));
    end

    // Annul a DIVU part-way through RUN on the UNROLL=1 unit.
    rose = 1'b0;
    op = 3'd1; opd1 = 32'h1234_5678; opd2 = 32'h1234; acc = '0; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (if1.ready_o) rose = 1'b1;
    end
    annul = 1'b1;
    tick();
    chk("annul busy u1", 64'(if1.busy_o), 64'd0);
    chk("annul ready u1", 64'(if1.ready_o), 64'd0);
    chk("annul busy u4", 64'(if4.busy_o), 64'd0);
    chk("annul ready u4", 64'(if4.ready_o), 64'd0);
    chk("annul result kept u1", if1.result_o, last_res1);
    annul = 1'b0;
    start = 1'b0;
    repeat (3) begin
      tick();
      if (if1.ready_o) rose = 1'b1;
    end
    chk("annul ready never rose u1", 64'(rose), 64'd0);
    model(3'd1, 32'h1234_5678, 32'h1234, 64'd0, er, edz);
    run_op(3'd1, 32'h1234_5678, 32'h1234, 64'd0, er, edz, 1'b0, "after annul");

    // Asynchronous reset in the middle of a MULTU.
    op = 3'd3; opd1 = 32'hFFFF_0001; opd2 = 32'h0001_FFFF; acc = '0; start = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    chk("rst result u1", if1.result_o, 64'd0);
    chk("rst result u4", if4.result_o, 64'd0);
    chk("rst busy u1", 64'(if1.busy_o), 64'd0);
    chk("rst ready u4", 64'(if4.ready_o), 64'd0);
    chk("rst dz u1", 64'(if1.div_zero_o), 64'd0);
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    model(3'd2, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'd0, er, edz);
    run_op(3'd2, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'd0, er, edz, 1'b0, "after rst");

    for (int i = 0; i < 150; i++) begin
      ro   = 3'($urandom_range(0, 7));
      ra   = pick();
      rb   = pick();
      racc = {$urandom, $urandom};
      model(ro, ra, rb, racc, er, edz);
      run_op(ro, ra, rb, racc, er, edz, 1'b1, $sformatf("rnd%0d op%0d", i, ro));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Iterative multiply/divide unit for the execute stage. It is parametrised in operand width and bits retired per cycle, and covers signed and unsigned divide, multiply, and multiply-accumulate/subtract into a 2×WIDTH HI/LO value. The execute stage holds `start_i` and stable operands, stalling until `ready_o`. Results go to the HI/LO write path.

## Interface
- `WIDTH`, 32: operand width; must be even.
- `UNROLL`, 1: bits retired per RUN cycle; must divide WIDTH (1, 2, 4).
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start_i` input 1: request; held high with stable inputs until `ready_o` is seen.
- `annul_i` input 1: cancel the current operation (flush or exception).
- `op_i` input 3: DIV, DIVU, MULT, MULTU, MADD, MADDU, MSUB, MSUBU.
- `opdata1_i` input WIDTH: dividend or multiplicand.
- `opdata2_i` input WIDTH: divisor or multiplier.
- `acc_i` input 2×WIDTH: forwarded {HI,LO}, used by MADD/MSUB variants.
- `result_o` output 2×WIDTH: divide gives {remainder, quotient}; multiply gives product or accumulated value. Reset value 0.
- `ready_o` output 1: result valid. Reset value 0.
- `busy_o` output 1: high in RUN and FIX. Reset value 0.
- `div_zero_o` output 1: divide by zero, valid with `ready_o`. Reset value 0.

## Operation
- States: IDLE, RUN, FIX, DONE.
- **IDLE**
  - `start_i`=1 and `annul_i`=0: latch operands and `acc_i`.
  - Signed ops latch |opdata1| and |opdata2|. Record quotient sign = sign1^sign2, remainder sign = sign1, product sign = sign1^sign2.
  - Divide with `opdata2_i`=0: go to DONE with `result_o`=0 and `div_zero_o`=1.
  - Otherwise go to RUN with count N = WIDTH/UNROLL.
- **RUN**: each cycle performs UNROLL steps.
  - Divide: restoring, MSB first. Shift the partial remainder left by one and bring in the next dividend bit. If partial remainder ≥ divisor, subtract it and set the quotient bit to 1.
  - Multiply: shift-add, LSB first, into a 2×WIDTH accumulator.
  - Count decrements; go to FIX when it reaches 0.
- **FIX**: one cycle.
  - Apply two's-complement sign correction to quotient, remainder and product.
  - MADD/MADDU: result = acc + product.
  - MSUB/MSUBU: result = acc − product.
  - All arithmetic is modulo 2^(2×WIDTH).
  - Go to DONE.
- **DONE**
  - `ready_o`=1; `result_o` and `div_zero_o` are held.
  - When `start_i`=0, go to IDLE; `ready_o` falls and `div_zero_o` clears.
- Annul: `annul_i`=1 in any state forces IDLE on the next edge. `ready_o`=0 and `busy_o`=0 from then on. `result_o` is unchanged. `annul_i` beats `start_i`.
- Signed DIV of most-negative by −1: quotient = most-negative (0x80000000 at WIDTH=32), remainder 0, no flag.
- Reset mid-operation: all outputs go to 0 and the state goes to IDLE immediately.

## Timing
- Take `start_i` high in cycle 0 with the unit in IDLE.
- RUN occupies cycles 1..N and FIX occupies cycle N+1.
- `ready_o` is high from cycle N+2. Total latency is N+2, which is 34 at WIDTH=32, UNROLL=1.
- Divide by zero: `ready_o` is high from cycle 1.
- `ready_o` stays high while `start_i` stays high. The cycle after `start_i` falls, the unit is in IDLE. Earliest back-to-back start is 2 cycles after `ready_o` rises.
- Inputs are sampled only in IDLE. Changes to operands during RUN are ignored.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `muldiv_pkg`:
  - `muldiv_op_t` enum for the op encodings.
  - `muldiv_state_t` enum {IDLE, RUN, FIX, DONE}.
  - Helper predicates `is_div`, `is_signed`, `is_acc`, `is_sub`.
- Sub-module `muldiv_step`: one combinational step, divide or multiply selected by a mode bit. It is instantiated UNROLL times in a chain inside `muldiv_iter`.
- Top level holds the FSM, counter, sign flags, latched accumulator, and FIX datapath.

## Test plan
- DIV −7/2 (0xFFFFFFF9, 0x2), UNROLL=1 → cycle 34: `result_o`=0xFFFFFFFF_FFFFFFFD (remainder −1, quotient −3), `div_zero_o`=0.
- DIVU 0xFFFFFFFF/0x10 → {0x0000000F, 0x0FFFFFFF}. DIV 0x80000000/0xFFFFFFFF → {0, 0x80000000}.
- DIV x/0 → `ready_o` and `div_zero_o` high at cycle 1, `result_o`=0. Dropping `start_i` returns to IDLE and clears the flag.
- Multiply:
  - MULT 0x80000000×0x80000000 → 0x40000000_00000000.
  - MULTU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE_00000001.
  - MSUB acc=0x10, 3×5 → 0x1.
  - MADD acc=0, −2×3 → 0xFFFFFFFF_FFFFFFFA.
- Annul and reset:
  - `annul_i` at cycle 10 of DIVU → `busy_o`=0 at cycle 11 and `ready_o` never rises. The next start completes correctly in 34 cycles.
  - `rst` low at cycle 5 → all outputs 0 immediately.
- UNROLL=4, WIDTH=32: MULTU 12345×6789 → 83810205 (0x04FED79D), `ready_o` at cycle 10. Repeat the divide cases at UNROLL=4.
